// File: rtl/program_counter_ras.sv
// rtl/program_counter_ras.sv - fetch-stage program counter with circular return-address stack
// Optional feature: define PC_RAS_TRAP_EN to trap on stack overflow/underflow instead of overwrite/increment.
module program_counter_ras #(
   parameter int              PC_W         = 16,
   parameter int              BR_IMM_W     = 6,
   parameter int              JMP_IMM_W    = 12,
   parameter int              INSN_BYTES   = 2,
   parameter int              RAS_DEPTH    = 4,
   parameter logic [PC_W-1:0] RESET_VECTOR = '0,
   parameter logic [PC_W-1:0] TRAP_VECTOR  = 16'hFFF0
) (
   input  logic                           clk_pi,
   input  logic                           reset_n_pi,
   input  logic                           clk_en_pi,
   input  logic                           branch_taken_pi,
   input  logic [BR_IMM_W-1:0]            branch_immediate_pi,
   input  logic                           jump_taken_pi,
   input  logic [JMP_IMM_W-1:0]           jump_immediate_pi,
   input  logic                           call_pi,
   input  logic                           ret_pi,
   output logic [PC_W-1:0]                pc_po,
   output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count_po,
   output logic                           ras_err_po
);

   localparam int CW = $clog2(RAS_DEPTH + 1);
   localparam int PW = $clog2(RAS_DEPTH);

   logic [PC_W-1:0] pc_q, pc_d;
   logic [PW-1:0]   ptr_q, ptr_d, ptr_inc, ptr_dec;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [PC_W-1:0] ras_mem_q [RAS_DEPTH];
   logic [PC_W-1:0] seq, br_ext, jmp_ext;
   logic            push_en, ras_full, ras_empty;

   assign seq       = pc_q + PC_W'(INSN_BYTES);
   assign br_ext    = {{(PC_W-BR_IMM_W){branch_immediate_pi[BR_IMM_W-1]}}, branch_immediate_pi};
   assign jmp_ext   = {{(PC_W-JMP_IMM_W){jump_immediate_pi[JMP_IMM_W-1]}}, jump_immediate_pi};
   assign ras_full  = (cnt_q == CW'(RAS_DEPTH));
   assign ras_empty = (cnt_q == '0);

   // Pointer wraps explicitly so non-power-of-two depths stay circular
   assign ptr_inc = (ptr_q == PW'(RAS_DEPTH-1)) ? '0 : ptr_q + PW'(1);
   assign ptr_dec = (ptr_q == '0) ? PW'(RAS_DEPTH-1) : ptr_q - PW'(1);

`ifdef PC_RAS_TRAP_EN
   logic err_q, err_d;
   assign ras_err_po = err_q;
`else
   assign ras_err_po = 1'b0;
`endif

   always_comb begin
      pc_d    = pc_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      push_en = 1'b0;
`ifdef PC_RAS_TRAP_EN
      err_d   = err_q;
`endif
      if (clk_en_pi) begin
         if (ret_pi) begin
            if (ras_empty) begin
`ifdef PC_RAS_TRAP_EN
               pc_d  = TRAP_VECTOR;
               err_d = 1'b1;
`else
               pc_d  = seq;
`endif
            end else begin
               pc_d  = ras_mem_q[ptr_q];
               ptr_d = ptr_dec;
               cnt_d = cnt_q - CW'(1);
            end
         end else if (call_pi) begin
`ifdef PC_RAS_TRAP_EN
            if (ras_full) begin
               pc_d  = TRAP_VECTOR;
               err_d = 1'b1;
            end else begin
               pc_d    = seq + jmp_ext;
               push_en = 1'b1;
               ptr_d   = ptr_inc;
               cnt_d   = cnt_q + CW'(1);
            end
`else
            // When full, the push lands on the oldest entry and count saturates
            pc_d    = seq + jmp_ext;
            push_en = 1'b1;
            ptr_d   = ptr_inc;
            if (!ras_full) cnt_d = cnt_q + CW'(1);
`endif
         end else if (branch_taken_pi) begin
            pc_d = seq + br_ext;
         end else if (jump_taken_pi) begin
            pc_d = seq + jmp_ext;
         end else begin
            pc_d = seq;
         end
      end
   end

   always_ff @(posedge clk_pi or negedge reset_n_pi) begin
      if (!reset_n_pi) begin
         pc_q  <= RESET_VECTOR;
         ptr_q <= '0;
         cnt_q <= '0;
`ifdef PC_RAS_TRAP_EN
         err_q <= 1'b0;
`endif
      end else begin
         pc_q  <= pc_d;
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
`ifdef PC_RAS_TRAP_EN
         err_q <= err_d;
`endif
      end
   end

   always_ff @(posedge clk_pi) begin
      if (push_en) ras_mem_q[ptr_inc] <= seq;
   end

   assign pc_po        = pc_q;
   assign ras_count_po = cnt_q;

endmodule

// File: tb/tb_program_counter_ras.sv
// tb/tb_program_counter_ras.sv - scoreboard bench for program_counter_ras against a queue-based stack model
module tb_program_counter_ras;
   localparam int          DEPTH = 4;
   localparam logic [15:0] TRAP  = 16'hFFF0;

   logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0;
   logic        br = 1'b0, jmp = 1'b0, call = 1'b0, ret = 1'b0;
   logic [5:0]  bimm = '0;
   logic [11:0] jimm = '0;
   logic [15:0] pc_po;
   logic [2:0]  ras_count_po;
   logic        ras_err_po;

   program_counter_ras dut (
      .clk_pi(clk), .reset_n_pi(rst_n), .clk_en_pi(en),
      .branch_taken_pi(br), .branch_immediate_pi(bimm),
      .jump_taken_pi(jmp), .jump_immediate_pi(jimm),
      .call_pi(call), .ret_pi(ret),
      .pc_po(pc_po), .ras_count_po(ras_count_po), .ras_err_po(ras_err_po)
   );

   always #5 clk = ~clk;

   typedef struct { logic [15:0] pc; int cnt; bit err; } exp_t;
   exp_t sb[$];
   int checks = 0, errors = 0;

   logic [15:0] m_pc = 16'h0;
   logic [15:0] stk[$];
   bit          m_err = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: stack is a queue whose back is the top of stack
   function automatic void model(input bit e, r, c, b, j, input logic [5:0] bi, input logic [11:0] ji);
      logic [15:0]        seq;
      logic signed [15:0] boff, joff;
      seq  = m_pc + 16'd2;
      boff = $signed(bi);
      joff = $signed(ji);
      if (!e) return;
      if (r) begin
         if (stk.size() == 0) begin
`ifdef PC_RAS_TRAP_EN
            m_pc = TRAP; m_err = 1'b1;
`else
            m_pc = seq;
`endif
         end else m_pc = stk.pop_back();
      end else if (c) begin
         if (stk.size() == DEPTH) begin
`ifdef PC_RAS_TRAP_EN
            m_pc = TRAP; m_err = 1'b1;
`else
            void'(stk.pop_front());
            stk.push_back(seq);
            m_pc = seq + joff;
`endif
         end else begin
            stk.push_back(seq);
            m_pc = seq + joff;
         end
      end else if (b) m_pc = seq + boff;
      else if (j)     m_pc = seq + joff;
      else            m_pc = seq;
   endfunction

   task automatic step(input bit e, r, c, b, j, input logic [5:0] bi, input logic [11:0] ji);
      exp_t x;
      en = e; ret = r; call = c; br = b; jmp = j; bimm = bi; jimm = ji;
      model(e, r, c, b, j, bi, ji);
      @(posedge clk);
      x.pc = m_pc; x.cnt = stk.size(); x.err = m_err;
      sb.push_back(x);
      #1;
   endtask

   task automatic idle();
      step(1, 0, 0, 0, 0, '0, '0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_pc", pc_po, 16'h0000);
      check("async_rst_cnt", ras_count_po, 0);
      check("async_rst_err", ras_err_po, 0);
      m_pc = 16'h0; stk.delete(); m_err = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   always @(negedge clk) begin
      exp_t x;
      if (sb.size() > 0) begin
         x = sb.pop_front();
         check("sb_pc", pc_po, x.pc);
         check("sb_cnt", ras_count_po, x.cnt);
         check("sb_err", ras_err_po, x.err);
      end
   end

   initial begin
      #1;
      check("rst_pc", pc_po, 16'h0000);
      check("rst_cnt", ras_count_po, 0);
      check("rst_err", ras_err_po, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      idle(); check("inc1", pc_po, 16'h0002);
      idle(); check("inc2", pc_po, 16'h0004);
      idle(); check("inc3", pc_po, 16'h0006);
      check("inc_cnt", ras_count_po, 0);
      do_reset();

      step(1, 0, 0, 0, 1, '0, 12'h00E);      check("jmp_to_10", pc_po, 16'h0010);
      step(1, 0, 0, 1, 0, 6'b111110, '0);    check("br_neg2", pc_po, 16'h0010);
      step(1, 0, 0, 0, 1, '0, 12'h004);      check("jmp_4", pc_po, 16'h0016);
      step(1, 0, 0, 1, 1, 6'h02, 12'h100);   check("br_beats_jmp", pc_po, 16'h001A);
      step(1, 0, 0, 0, 1, '0, 12'h004);      check("jmp_to_20", pc_po, 16'h0020);
      step(1, 0, 1, 0, 0, '0, 12'h010);      check("call_pc", pc_po, 16'h0032);
      check("call_cnt", ras_count_po, 1);
      repeat (3) idle();
      step(1, 1, 0, 0, 0, '0, '0);           check("ret_pc", pc_po, 16'h0022);
      check("ret_cnt", ras_count_po, 0);

      for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 0, '0, 12'h020);
      check("nest_cnt_sat", ras_count_po, DEPTH);
      for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0, '0, '0);
      step(1, 1, 1, 0, 0, '0, 12'h040);
      do_reset();

      step(1, 1, 0, 0, 0, '0, '0);
`ifdef PC_RAS_TRAP_EN
      check("underflow_trap", pc_po, TRAP);
      check("underflow_err", ras_err_po, 1);
`else
      check("underflow_inc", pc_po, 16'h0002);
`endif
      step(1, 0, 1, 0, 0, '0, 12'h008);
      step(1, 1, 0, 0, 0, '0, '0);
      repeat (4) step(0, 1, 1, 1, 0, 6'h05, 12'h123);

      do_reset();
      step(1, 0, 0, 0, 1, '0, 12'hFFC);      check("to_fffe", pc_po, 16'hFFFE);
      idle();                                check("wrap_0", pc_po, 16'h0000);

      for (int i = 0; i < 600; i++) begin
         if (i % 150 == 149) do_reset();
         step($urandom_range(0, 7) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
              6'($urandom), 12'($urandom));
      end

      @(negedge clk);
      #1;
      check("sb_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/program_counter_ras.md
# program_counter_ras

Parametrised program counter with an integrated return-address stack (RAS). It sits in the fetch stage and drives the instruction-memory address. Each enabled cycle it advances by one instruction word, redirects on PC-relative branches and jumps, and supports call/return through a circular hardware stack of configurable depth. It is the next generation of the fixed 16-bit counter, adding width/step generalisation, an asynchronous reset and subroutine linkage.

## Interface
- PC_W, 16, program counter width in bits
- BR_IMM_W, 6, branch immediate width (two's complement)
- JMP_IMM_W, 12, jump/call immediate width (two's complement)
- INSN_BYTES, 2, PC increment per instruction
- RAS_DEPTH, 4, return-address stack entries (≥2)
- RESET_VECTOR, 0, PC value on reset
- TRAP_VECTOR, 16'hFFF0, PC value on stack error (used only with PC_RAS_TRAP_EN)

Ports:
- clk_pi  in  1  clock, rising edge
- reset_n_pi  in  1  asynchronous, active-low reset
- clk_en_pi  in  1  advance enable; low = hold all state
- branch_taken_pi  in  1  take PC-relative branch
- branch_immediate_pi  in  BR_IMM_W  signed branch offset
- jump_taken_pi  in  1  take PC-relative jump
- jump_immediate_pi  in  JMP_IMM_W  signed jump/call offset
- call_pi  in  1  jump via jump_immediate_pi and push return address
- ret_pi  in  1  pop return address into PC
- pc_po  out  PC_W  current PC
- ras_count_po  out  $clog2(RAS_DEPTH+1)  valid stack entries
- ras_err_po  out  1  sticky stack overflow/underflow flag

## Operation
- Define seq = PC + INSN_BYTES. Offsets are sign-extended to PC_W. All arithmetic is modulo 2^PC_W and wraps silently (PC at max − 1 + 2 gives 0).
- Priority per enabled cycle, highest first: ret_pi, call_pi, branch_taken_pi, jump_taken_pi, increment.
  - ret: PC <= stack top; pop; count−1.
  - call: PC <= seq + sext(jump_immediate_pi); push seq; count+1.
  - branch: PC <= seq + sext(branch_immediate_pi).
  - jump: PC <= seq + sext(jump_immediate_pi).
  - none: PC <= seq.
- A lower-priority request asserted in the same cycle as a higher one is ignored entirely. For example, call with ret performs only the pop.
- Stack storage:
  - RAS_DEPTH entries of PC_W bits with a circular top pointer.
  - Push writes at pointer+1 and advances the pointer.
  - Pop reads at the pointer and retreats it.
- Overflow (call when count = RAS_DEPTH), default behaviour: the push overwrites the oldest entry and count stays at RAS_DEPTH.
- Underflow (ret when count = 0), default behaviour: treated as a plain increment (PC <= seq). Pointer and count are unchanged.
- clk_en_pi low: PC, pointer, count, storage and ras_err_po all hold. All request inputs are ignored.

## Timing
- Reset (reset_n_pi low, asynchronous, no clock required):
  - pc_po = RESET_VECTOR.
  - ras_count_po = 0, pointer = 0, ras_err_po = 0.
  - Stack contents are don't-care.
- Reset release is sampled synchronously. The first enabled rising edge after release updates the PC.
- All requests are sampled on the rising edge and take effect on pc_po in the same edge: one-cycle latency, no bubbles.
- Stack data is registered. A ret in the cycle immediately after a call returns the address just pushed.
- Reset asserted mid-operation clears everything at once. Any pending request is lost.

## Configuration
- PC_RAS_TRAP_EN defined:
  - Overflow or underflow does not modify the stack. Instead PC <= TRAP_VECTOR.
  - ras_err_po sets on that edge and stays high until reset.
  - Further calls/rets continue to be processed normally after the trap.
- PC_RAS_TRAP_EN undefined:
  - Overwrite/increment behaviour as in Operation.
  - ras_err_po is tied to 0.
  - TRAP_VECTOR is unused.

## Test plan
- Reset, then 3 enabled cycles with no requests -> pc_po 0, 2, 4, 6; ras_count_po 0. Assert reset_n_pi low between edges -> pc_po 0 immediately.
- PC=0x0010, branch_immediate_pi=6'b111110 (−2) -> PC 0x0010. Jump with 12'h004 -> PC 0x0016. Branch+jump together -> branch wins.
- PC=0x0020, call with 12'h010 -> PC 0x0032, count 1. Three enabled idle cycles, then ret -> PC 0x0022, count 0.
- Five nested calls with RAS_DEPTH=4, no macro -> count saturates at 4. Five rets -> last four return addresses in LIFO order, then the 5th ret increments PC.
- With PC_RAS_TRAP_EN: ret at count 0 -> PC=TRAP_VECTOR and ras_err_po=1, held until reset. Fifth call at full -> same trap, stack contents intact.
- clk_en_pi low for 4 cycles with call, ret and branch asserted -> pc_po, ras_count_po and ras_err_po unchanged. PC at 0xFFFE with increment -> 0x0000.
